// File: rtl/ras_pkg.sv
// ras_pkg: shared types and width helpers for the checkpointed return-address
// stack (ras_ckpt) and its checkpoint bank.
//   ras_ptr_w(n)  : pointer/index width, max(1, $clog2(n))
//   ras_cnt_w(n)  : width of an occupancy counter ranging over 0..n
//   ras_ckpt_t    : checkpoint slot {tos, count, top_addr} for the default
//                   configuration; ras_ckpt declares the same layout from its
//                   own parameters so that non-default builds stay consistent.
package ras_pkg;

    localparam int RAS_DEPTH_DEF   = 2;
    localparam int RAS_VLEN_DEF    = 64;
    localparam int RAS_NR_CKPT_DEF = 4;

    function automatic int ras_ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ras_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int RAS_PTR_W_DEF = ras_ptr_w(RAS_DEPTH_DEF);
    localparam int RAS_CNT_W_DEF = ras_cnt_w(RAS_DEPTH_DEF);

    typedef struct packed {
        logic [RAS_PTR_W_DEF-1:0] tos;
        logic [RAS_CNT_W_DEF-1:0] count;
        logic [RAS_VLEN_DEF-1:0]  top_addr;
    } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt_bank.sv
// ras_ckpt_bank: NR_CKPT-entry checkpoint register file, one write port and
// one read port. The read is combinational from the slot registers, so a
// write and a read of the same slot in one cycle returns the old contents.
//   clk_i, rst_i : clock, synchronous active-high reset (clears all slots)
//   we_i, waddr_i, wdata_i : write port
//   raddr_i, rdata_o       : read port
module ras_ckpt_bank #(
    parameter int NR_CKPT = 4,
    parameter int ID_W    = 2,
    parameter int W       = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [ID_W-1:0] waddr_i,
    input  logic [W-1:0]    wdata_i,
    input  logic [ID_W-1:0] raddr_i,
    output logic [W-1:0]    rdata_o
);

    logic [W-1:0] slot_r [NR_CKPT];

    // Slot storage: cleared on reset, otherwise written through the single port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_CKPT; i++) begin
                slot_r[i] <= '0;
            end
        end else if (we_i) begin
            slot_r[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = slot_r[raddr_i];

endmodule

// File: rtl/ras_ckpt_chk.sv
// ras_ckpt_chk: simulation-only checks for ras_ckpt.
//   - DEPTH and NR_CKPT must be powers of two.
//   - Warns when a slot is restored that was not saved since reset/flush.
// Inputs mirror the ras_ckpt control ports; no outputs.
module ras_ckpt_chk #(
    parameter int DEPTH   = 2,
    parameter int NR_CKPT = 4,
    parameter int ID_W    = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            flush_i,
    input logic            ckpt_save_i,
    input logic [ID_W-1:0] ckpt_save_id_i,
    input logic            ckpt_restore_i,
    input logic [ID_W-1:0] ckpt_restore_id_i
);

    localparam bit DEPTH_POW2 = ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= 2);
    localparam bit NRCK_POW2  = ((NR_CKPT & (NR_CKPT - 1)) == 0) && (NR_CKPT >= 1);

    logic [NR_CKPT-1:0] saved_r;

    // Track which slots hold a checkpoint taken since the last reset or flush.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            saved_r <= '0;
        end else if (ckpt_save_i) begin
            saved_r[ckpt_save_id_i] <= 1'b1;
        end
    end

    a_depth_pow2: assert property (@(posedge clk_i) DEPTH_POW2)
        else $error("ras_ckpt: DEPTH must be a power of two >= 2");

    a_nrck_pow2: assert property (@(posedge clk_i) NRCK_POW2)
        else $error("ras_ckpt: NR_CKPT must be a power of two >= 1");

    a_restore_saved: assert property (@(posedge clk_i) disable iff (rst_i)
        (ckpt_restore_i && !flush_i) |-> saved_r[ckpt_restore_id_i])
        else $warning("ras_ckpt: restore from slot %0d not saved since reset/flush",
                      ckpt_restore_id_i);

endmodule

// File: rtl/ras_ckpt.sv
// ras_ckpt: parametrised return-address stack with circular overwrite,
// same-cycle push+pop replace and NR_CKPT speculative checkpoints.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   flush_i             : empty the stack (data/checkpoints left as is)
//   push_i, push_addr_i : call - push a return address
//   pop_i               : return - pop the top entry
//   ckpt_save_i/_id_i   : snapshot {tos, count, entry[tos]} into a slot
//   ckpt_restore_i/_id_i: reload tos/count and rewrite entry[tos] from a slot
//   top_addr_o          : entry[tos]
//   top_valid_o         : count != 0
//   count_o             : number of valid entries
// All outputs come straight from state registers.
module ras_ckpt
    import ras_pkg::*;
#(
    parameter int DEPTH   = RAS_DEPTH_DEF,
    parameter int VLEN    = RAS_VLEN_DEF,
    parameter int NR_CKPT = RAS_NR_CKPT_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          push_i,
    input  logic [VLEN-1:0]               push_addr_i,
    input  logic                          pop_i,
    input  logic                          ckpt_save_i,
    input  logic [ras_ptr_w(NR_CKPT)-1:0] ckpt_save_id_i,
    input  logic                          ckpt_restore_i,
    input  logic [ras_ptr_w(NR_CKPT)-1:0] ckpt_restore_id_i,
    output logic [VLEN-1:0]               top_addr_o,
    output logic                          top_valid_o,
    output logic [ras_cnt_w(DEPTH)-1:0]   count_o
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = ras_cnt_w(DEPTH);
    localparam int ID_W  = ras_ptr_w(NR_CKPT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    typedef struct packed {
        logic [PTR_W-1:0] tos;
        logic [CNT_W-1:0] count;
        logic [VLEN-1:0]  top_addr;
    } ckpt_t;

    logic [PTR_W-1:0] tos_r;
    logic [CNT_W-1:0] cnt_r;
    logic [VLEN-1:0]  data_r [DEPTH];

    logic [PTR_W-1:0] tos_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             wr_en_s;
    logic [PTR_W-1:0] wr_idx_s;
    logic [VLEN-1:0]  wr_data_s;
    logic [PTR_W-1:0] tos_inc_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             save_en_s;
    ckpt_t            save_slot_s;
    ckpt_t            rest_slot_s;

    // Pointer arithmetic wraps naturally in PTR_W bits; count saturates at DEPTH.
    assign tos_inc_s = tos_r + PTR_W'(1);
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_W'(1));

    // Snapshot reflects the state before any update of this cycle.
    assign save_en_s   = ckpt_save_i & ~flush_i;
    assign save_slot_s = '{tos: tos_r, count: cnt_r, top_addr: data_r[tos_r]};

    ras_ckpt_bank #(
        .NR_CKPT (NR_CKPT),
        .ID_W    (ID_W),
        .W       ($bits(ckpt_t))
    ) u_bank (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (save_en_s),
        .waddr_i (ckpt_save_id_i),
        .wdata_i (save_slot_s),
        .raddr_i (ckpt_restore_id_i),
        .rdata_o (rest_slot_s)
    );

    // Next-state selection: flush > restore > push/pop.
    always_comb begin
        tos_nxt_s = tos_r;
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = tos_r;
        wr_data_s = push_addr_i;
        if (flush_i) begin
            tos_nxt_s = '0;
            cnt_nxt_s = '0;
        end else if (ckpt_restore_i) begin
            tos_nxt_s = rest_slot_s.tos;
            cnt_nxt_s = rest_slot_s.count;
            wr_en_s   = 1'b1;
            wr_idx_s  = rest_slot_s.tos;
            wr_data_s = rest_slot_s.top_addr;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    tos_nxt_s = tos_inc_s;
                    cnt_nxt_s = cnt_inc_s;
                    wr_en_s   = 1'b1;
                    wr_idx_s  = tos_inc_s;
                end
                2'b01: begin
                    if (cnt_r != '0) begin
                        tos_nxt_s = tos_r - PTR_W'(1);
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end else begin
                        tos_nxt_s = tos_r;
                        cnt_nxt_s = cnt_r;
                    end
                end
                2'b11: begin
                    // Replace in place when non-empty; on empty it is a plain push.
                    if (cnt_r != '0) begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = tos_r;
                    end else begin
                        tos_nxt_s = tos_inc_s;
                        cnt_nxt_s = cnt_inc_s;
                        wr_en_s   = 1'b1;
                        wr_idx_s  = tos_inc_s;
                    end
                end
                default: begin
                    wr_en_s = 1'b0;
                end
            endcase
        end
    end

    // Stack state registers; reset wins over every other input.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tos_r <= '0;
            cnt_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            tos_r <= tos_nxt_s;
            cnt_r <= cnt_nxt_s;
            if (wr_en_s) begin
                data_r[wr_idx_s] <= wr_data_s;
            end
        end
    end

    assign top_addr_o  = data_r[tos_r];
    assign top_valid_o = (cnt_r != '0);
    assign count_o     = cnt_r;

    ras_ckpt_chk #(
        .DEPTH   (DEPTH),
        .NR_CKPT (NR_CKPT),
        .ID_W    (ID_W)
    ) u_chk (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .flush_i           (flush_i),
        .ckpt_save_i       (ckpt_save_i),
        .ckpt_save_id_i    (ckpt_save_id_i),
        .ckpt_restore_i    (ckpt_restore_i),
        .ckpt_restore_id_i (ckpt_restore_id_i)
    );

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: directed scenarios plus randomized traffic for ras_ckpt,
// checked every cycle against a behavioural stack model kept in the bench.
module tb_ras_ckpt;

    localparam int DEPTH   = 2;
    localparam int VLEN    = 64;
    localparam int NR_CKPT = 4;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            push;
    logic [VLEN-1:0] push_addr;
    logic            pop;
    logic            save;
    logic [1:0]      save_id;
    logic            rest;
    logic [1:0]      rest_id;
    logic [VLEN-1:0] top_addr;
    logic            top_valid;
    logic [1:0]      count;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    ras_ckpt #(.DEPTH(DEPTH), .VLEN(VLEN), .NR_CKPT(NR_CKPT)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .push_i            (push),
        .push_addr_i       (push_addr),
        .pop_i             (pop),
        .ckpt_save_i       (save),
        .ckpt_save_id_i    (save_id),
        .ckpt_restore_i    (rest),
        .ckpt_restore_id_i (rest_id),
        .top_addr_o        (top_addr),
        .top_valid_o       (top_valid),
        .count_o           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int              m_tos = 0;
    int              m_cnt = 0;
    longint unsigned m_mem [DEPTH];
    int              c_tos [NR_CKPT];
    int              c_cnt [NR_CKPT];
    longint unsigned c_top [NR_CKPT];

    always @(posedge clk) begin
        int              s_tos;
        int              s_cnt;
        longint unsigned s_top;
        if (rst) begin
            m_tos = 0;
            m_cnt = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
            for (int i = 0; i < NR_CKPT; i++) begin
                c_tos[i] = 0; c_cnt[i] = 0; c_top[i] = 0;
            end
        end else begin
            s_tos = m_tos; s_cnt = m_cnt; s_top = m_mem[m_tos];
            if (flush) begin
                m_tos = 0;
                m_cnt = 0;
            end else if (rest) begin
                m_tos = c_tos[rest_id];
                m_cnt = c_cnt[rest_id];
                m_mem[m_tos] = c_top[rest_id];
            end else if (push && pop && m_cnt > 0) begin
                m_mem[m_tos] = push_addr;
            end else if (push) begin
                m_tos = (m_tos + 1) % DEPTH;
                m_mem[m_tos] = push_addr;
                m_cnt = (m_cnt < DEPTH) ? m_cnt + 1 : DEPTH;
            end else if (pop && m_cnt > 0) begin
                m_tos = (m_tos + DEPTH - 1) % DEPTH;
                m_cnt = m_cnt - 1;
            end
            if (save && !flush) begin
                c_tos[save_id] = s_tos;
                c_cnt[save_id] = s_cnt;
                c_top[save_id] = s_top;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", 64'(count), 64'(m_cnt));
            check("model_valid", 64'(top_valid), 64'(m_cnt != 0));
            if (m_cnt != 0) check("model_top", top_addr, m_mem[m_tos]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit r, input bit f, input bit pu, input logic [63:0] a,
                        input bit po, input bit sv, input int sid, input bit rs, input int rid);
        @(negedge clk);
        rst = r; flush = f; push = pu; push_addr = a; pop = po;
        save = sv; save_id = 2'(sid); rest = rs; rest_id = 2'(rid);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick(0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
    endtask

    task automatic lit(input string name, input int exp_cnt, input logic [63:0] exp_top);
        check({name, "_count"}, 64'(count), 64'(exp_cnt));
        check({name, "_valid"}, 64'(top_valid), 64'(exp_cnt != 0));
        if (exp_cnt != 0) check({name, "_top"}, top_addr, exp_top);
    endtask

    initial begin
        bit [NR_CKPT-1:0] saved;
        bit r, f, pu, po, sv, rs;
        int sid, rid;
        logic [63:0] a;

        rst = 1'b1; flush = 1'b0; push = 1'b0; push_addr = '0; pop = 1'b0;
        save = 1'b0; save_id = '0; rest = 1'b0; rest_id = '0;

        // Reset
        tick(1, 0, 0, 64'h0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 64'h0, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        lit("reset", 0, 64'h0);
        check("reset_top", top_addr, 64'h0);

        // 1: basic push/pop
        tick(0, 0, 1, 64'h1000, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 64'h2000, 0, 0, 0, 0, 0);
        lit("t1_push2", 2, 64'h2000);
        tick(0, 0, 0, 64'h0, 1, 0, 0, 0, 0);
        lit("t1_pop", 1, 64'h1000);

        // 2: overflow and underflow
        tick(0, 0, 1, 64'hA, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 64'hB, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 64'hC, 0, 0, 0, 0, 0);
        lit("t2_ovf", 2, 64'hC);
        tick(0, 0, 0, 64'h0, 1, 0, 0, 0, 0);
        lit("t2_pop1", 1, 64'hB);
        tick(0, 0, 0, 64'h0, 1, 0, 0, 0, 0);
        lit("t2_pop2", 0, 64'h0);
        tick(0, 0, 0, 64'h0, 1, 0, 0, 0, 0);
        lit("t2_unf", 0, 64'h0);

        // 3: push+pop replace, and at empty
        tick(0, 0, 1, 64'h1000, 0, 0, 0, 0, 0);
        lit("t3_setup", 1, 64'h1000);
        tick(0, 0, 1, 64'h5000, 1, 0, 0, 0, 0);
        lit("t3_repl", 1, 64'h5000);
        tick(0, 0, 0, 64'h0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 64'h5000, 1, 0, 0, 0, 0);
        lit("t3_empty", 1, 64'h5000);

        // 4: checkpoint save with pop, then restore
        tick(0, 0, 1, 64'h2000, 0, 0, 0, 0, 0);
        lit("t4_setup", 2, 64'h2000);
        tick(0, 0, 0, 64'h0, 1, 1, 3, 0, 0);
        lit("t4_savepop", 1, 64'h5000);
        tick(0, 0, 1, 64'h9, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 64'hF, 0, 0, 0, 0, 0);
        lit("t4_pushes", 2, 64'hF);
        tick(0, 0, 0, 64'h0, 0, 0, 0, 1, 3);
        lit("t4_restore", 2, 64'h2000);

        // 5: priority, and save+restore on the same slot
        tick(0, 1, 1, 64'h7777, 0, 0, 0, 1, 3);
        lit("t5_flush", 0, 64'h0);
        tick(0, 0, 1, 64'h111, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 64'h0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 64'h222, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 64'h333, 0, 0, 0, 0, 0);
        lit("t5_pre", 2, 64'h333);
        tick(0, 0, 0, 64'h0, 0, 1, 1, 1, 1);
        lit("t5_same_old", 1, 64'h111);
        tick(0, 0, 1, 64'h444, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 64'h0, 0, 0, 0, 1, 1);
        lit("t5_same_new", 2, 64'h333);

        // 6: reset mid-sequence overrides push; checkpoints cleared
        tick(0, 0, 1, 64'h555, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 64'h666, 0, 0, 0, 0, 0);
        lit("t6_rst", 0, 64'h0);
        check("t6_rst_top", top_addr, 64'h0);
        tick(0, 0, 0, 64'h0, 0, 0, 0, 1, 2);
        lit("t6_restore", 0, 64'h0);

        // Randomized traffic; restores only target slots saved since reset/flush.
        saved = '0;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            f   = ($urandom_range(0, 31) == 0);
            pu  = $urandom_range(0, 1) == 1;
            po  = $urandom_range(0, 1) == 1;
            sv  = ($urandom_range(0, 4) == 0);
            sid = $urandom_range(0, NR_CKPT - 1);
            rid = $urandom_range(0, NR_CKPT - 1);
            rs  = ($urandom_range(0, 7) == 0) && saved[rid];
            a   = {$urandom, $urandom};
            tick(r, f, pu, a, po, sv, sid, rs, rid);
            if (r || f) saved = '0;
            else if (sv) saved[sid] = 1'b1;
        end

        idle();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
